// File: rtl/param_data_memory.sv
// Multi-cycle data memory for the CPU memory stage: word-addressed byte-lane storage,
// a per-byte write mask, and a counter-timed busywait stall handshake.
module param_data_memory #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 6,
   parameter int LATENCY        = 5,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   writedata,
   input  logic [DATA_WIDTH/8-1:0] writemask,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    busywait
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = $clog2(LATENCY) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic                    wr_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NB-1:0]           wmask_q;
   logic [DATA_WIDTH-1:0]   readdata_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    rd_req, wr_req, commit, wr_commit;
   logic [DATA_WIDTH-1:0]   bmask, merged_d;

   // Simultaneous read and write is treated as no request at all.
   assign rd_req    = read & ~write;
   assign wr_req    = write & ~read;
   assign commit    = (state_q == BUSY) && (cnt_q == '0);
   assign wr_commit = commit & wr_q;

   genvar k;
   generate
      for (k = 0; k < NB; k++) begin : g_lane
         assign bmask[8*k +: 8] = {8{wmask_q[k]}};
      end
   endgenerate

   assign merged_d = (mem_q[addr_q] & ~bmask) | (wdata_q & bmask);

   // Stall is asserted in the request cycle itself so the CPU freezes before e0.
   assign busywait = reset & ((state_q == BUSY) ||
                              ((state_q == IDLE) && (rd_req | wr_req)));
   assign readdata = readdata_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         readdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_req | wr_req) begin
                  wr_q    <= wr_req;
                  addr_q  <= address;
                  wdata_q <= writedata;
                  wmask_q <= writemask;
                  cnt_q   <= CW'(LATENCY - 1);
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  if (!wr_q) readdata_q <= mem_q[addr_q];
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   generate
      if (CLEAR_ON_RESET != 0) begin : g_clr
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else if (wr_commit) begin
               mem_q[addr_q] <= merged_d;
            end
         end
      end else begin : g_keep
         // Reset forces the FSM to IDLE, so an interrupted write never reaches commit.
         always_ff @(posedge clock) begin
            if (wr_commit) mem_q[addr_q] <= merged_d;
         end
      end
   endgenerate
endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: a LATENCY=5 clearing instance and a
// LATENCY=1 instance that keeps its contents across reset.
module tb_param_data_memory;
   logic        clock = 1'b0;
   logic        reset;
   logic        read, write, busywait;
   logic [5:0]  address;
   logic [31:0] writedata, readdata;
   logic [3:0]  writemask;
   logic        read1, write1, bw1;
   logic [5:0]  a1;
   logic [31:0] d1, rd1;
   logic [3:0]  m1;

   int passed = 0;
   int total  = 0;
   int n;

   always #5 clock = ~clock;

   param_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(5), .CLEAR_ON_RESET(1)) dut (
      .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
      .writedata(writedata), .writemask(writemask), .readdata(readdata), .busywait(busywait));

   param_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .LATENCY(1), .CLEAR_ON_RESET(0)) dut1 (
      .clock(clock), .reset(reset), .read(read1), .write(write1), .address(a1),
      .writedata(d1), .writemask(m1), .readdata(rd1), .busywait(bw1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Called at a negedge while the selected DUT is IDLE; returns busywait-high cycles.
   task automatic access(input bit u, input bit wr, input logic [5:0] a,
                         input logic [31:0] d, input logic [3:0] m, output int cyc);
      if (u) begin read1 = !wr; write1 = wr; a1 = a; d1 = d; m1 = m; end
      else begin read = !wr; write = wr; address = a; writedata = d; writemask = m; end
      cyc = 0;
      #1;
      while ((u ? bw1 : busywait) && cyc < 20) begin
         cyc++;
         @(negedge clock); #1;
      end
      if (u) begin read1 = 1'b0; write1 = 1'b0; end
      else begin read = 1'b0; write = 1'b0; end
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0; read = 1'b1; write = 1'b0; address = '0; writedata = '0; writemask = '0;
      read1 = 1'b0; write1 = 1'b0; a1 = '0; d1 = '0; m1 = '0;

      // 1: reset state, then read address 0
      @(negedge clock); @(negedge clock);
      chk("rst_busy_low", {31'b0, busywait}, 32'h0);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_busy1", {31'b0, bw1}, 32'h0);
      reset = 1'b1;
      access(0, 0, 6'd0, 32'h0, 4'h0, n);
      chk("t1_busy_cycles", n, 6);
      chk("t1_readdata", readdata, 32'h0);
      access(1, 1, 6'd4, 32'h0BADC0DE, 4'hF, n);
      chk("l1_wr_cycles", n, 2);

      // 2: full-word write then read
      access(0, 1, 6'd5, 32'hDEADBEEF, 4'hF, n);
      chk("t2_wr_cycles", n, 6);
      access(0, 0, 6'd5, 32'h0, 4'h0, n);
      chk("t2_rd_cycles", n, 6);
      chk("t2_readdata", readdata, 32'hDEADBEEF);

      // 3: byte-masked write; writes leave readdata alone
      access(0, 1, 6'd7, 32'h11223344, 4'hF, n);
      access(0, 1, 6'd7, 32'hAABBCCDD, 4'b0101, n);
      chk("t3_rd_hold", readdata, 32'hDEADBEEF);
      access(0, 0, 6'd7, 32'h0, 4'h0, n);
      chk("t3_readdata", readdata, 32'h11BB33DD);

      // 4: read and write together is ignored
      read = 1'b1; write = 1'b1; address = 6'd5; writedata = 32'h0; writemask = 4'hF;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t4_busy_low", {31'b0, busywait}, 32'h0);
         @(negedge clock);
      end
      read = 1'b0; write = 1'b0;
      @(negedge clock);
      chk("t4_rd_hold", readdata, 32'h11BB33DD);
      access(0, 0, 6'd5, 32'h0, 4'h0, n);
      chk("t4_mem5", readdata, 32'hDEADBEEF);

      // 5: inputs changed during BUSY must not affect the latched write
      write = 1'b1; address = 6'd3; writedata = 32'hCAFEF00D; writemask = 4'hF;
      @(negedge clock);
      address = 6'd9; writedata = 32'h0;
      n = 1;
      #1;
      while (busywait && n < 20) begin n++; @(negedge clock); #1; end
      chk("t5_wr_cycles", n, 6);
      write = 1'b0;
      @(negedge clock);
      access(0, 0, 6'd9, 32'h0, 4'h0, n);
      chk("t5_mem9", readdata, 32'h0);
      access(0, 0, 6'd3, 32'h0, 4'h0, n);
      chk("t5_mem3", readdata, 32'hCAFEF00D);

      // 6: reset in the 3rd BUSY cycle aborts the write
      write = 1'b1; address = 6'd2; writedata = 32'h12345678; writemask = 4'hF;
      @(negedge clock); @(negedge clock); @(negedge clock);
      reset = 1'b0;
      #1;
      chk("t6_busy_drop", {31'b0, busywait}, 32'h0);
      chk("t6_readdata_rst", readdata, 32'h0);
      write = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      access(0, 0, 6'd2, 32'h0, 4'h0, n);
      chk("t6_rd_cycles", n, 6);
      chk("t6_mem2", readdata, 32'h0);
      access(0, 0, 6'd3, 32'h0, 4'h0, n);
      chk("t6_mem3_cleared", readdata, 32'h0);

      // LATENCY=1 instance: contents survive reset, 2-cycle stall
      chk("l1_rd_rst", rd1, 32'h0);
      access(1, 0, 6'd4, 32'h0, 4'h0, n);
      chk("l1_rd_cycles", n, 2);
      chk("l1_mem4_kept", rd1, 32'h0BADC0DE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
